hdmi_period_sequencer: RTL and testbench
========================================

# hdmi_period_sequencer

Pixel-clock timing generator and period sequencer for the HDMI transmitter. It sits directly upstream of the three per-channel serializers. Each cycle it supplies the shared `STATE_t` period code, per-channel 2-bit control codes (sync and CTL preamble bits) and pixel coordinates. It also runs a one-packet-per-line handshake with the auxiliary packet buffer that feeds data-island content.

## Interface
Parameters:
- `H_ACTIVE`, 640, active pixels per line
- `H_FRONT`, 16, horizontal front porch
- `H_SYNC`, 96, hsync width
- `H_BACK`, 48, horizontal back porch
- `V_ACTIVE`, 480, active lines
- `V_FRONT`, 10, vertical front porch
- `V_SYNC`, 2, vsync width
- `V_BACK`, 33, vertical back porch
- `SYNC_ACTIVE`, 1'b0, asserted level of hsync/vsync
- `ISLAND_START`, 10, clocks after `H_ACTIVE` at which the data-island preamble begins

Ports:
- `clk` in 1: pixel clock
- `rst_n` in 1: reset; asynchronous, active-low
- `auxReady` in 1: packet buffer holds a complete 32-character packet
- `auxStart` out 1: one-cycle pulse on the first `AUXIL_ISLAND` character; the buffer pops the packet
- `auxIndex` out 5: character index 0..31 within the island
- `state` out `STATE_t`: period code for all serializers
- `ctrl0` out 2: channel 0 control code, `{vsync, hsync}`
- `ctrl1` out 2: channel 1 control code, `{CTL1, CTL0}`
- `ctrl2` out 2: channel 2 control code, `{CTL3, CTL2}`
- `pixelX` out 11: current `hCount`
- `pixelY` out 10: current `vCount`
- `videoActive` out 1: `state == VIDEO_ISLAND`

## Operation
- Counters:
  - `hCount` runs 0..H_TOTAL-1 and `vCount` runs 0..V_TOTAL-1. Both wrap to 0.
  - `H_TOTAL` is the sum of the H parameters; `V_TOTAL` is the sum of the V parameters.
  - `vCount` increments when `hCount` wraps.
- Active region: `hCount < H_ACTIVE && vCount < V_ACTIVE` gives `VIDEO_ISLAND`.
- Sync timing:
  - hsync is asserted for `H_ACTIVE+H_FRONT <= hCount < H_ACTIVE+H_FRONT+H_SYNC`.
  - vsync uses the analogous window on `vCount`.
  - Deasserted level is `~SYNC_ACTIVE`.
- Video lead-in, only when the next line is active (`vNext < V_ACTIVE`):
  - `hCount` in `[H_TOTAL-10, H_TOTAL-3]`: `VIDEO_PREAMBLE`, CTL3..0 = 0001.
  - `hCount` in `[H_TOTAL-2, H_TOTAL-1]`: `VIDEO_GUARD`.
- Island request: `auxReady` is sampled at `hCount == H_ACTIVE` on every line, including blanking lines, into `islandPending`.
- Island window (only if `islandPending`), with base `B = H_ACTIVE+ISLAND_START`:
  - `AUXIL_PREAMBLE` for 8 clocks, starting at B; CTL3..0 = 0101.
  - `AUXIL_GUARD` for 2 clocks, starting at B+8.
  - `AUXIL_ISLAND` for 32 clocks, starting at B+10. `auxStart` pulses at B+10; `auxIndex` runs 0..31.
  - `AUXIL_GUARD` for 2 clocks, starting at B+42.
  - Return to `CONTROL` at B+44. `islandPending` clears here.
- All other cycles: `CONTROL`, with CTL bits 0.
- CTL bits are 0 in every state except the two preambles.
- `ctrl0` always carries the current syncs. Channel 0 therefore gets correct TERC4 guard and sync content.

## Timing
- `state`, `ctrl*`, `pixelX`, `pixelY`, `auxIndex`, `auxStart` and `videoActive` are all registered. In any cycle they describe the same character.
- Reset values:
  - `hCount = 0`, `vCount = V_ACTIVE` (first blanking line).
  - `state = CONTROL`, `auxStart = 0`, `auxIndex = 0`, `islandPending = 0`.
  - CTL bits 0, syncs deasserted.
- First edge after release: counters advance; an active frame begins after `V_TOTAL-V_ACTIVE` lines.
- `auxReady` is ignored outside the sample cycle. A packet becoming ready mid-line waits for the next line.
- At most one island per line, never overlapping the video lead-in.
- Parameters must satisfy `H_TOTAL-H_ACTIVE >= ISLAND_START+44+12+10`; this is checked by an elaboration assertion.
- `ISLAND_START >= 4`, so each preamble is preceded by at least 12 control characters.
- Reset asserted mid-island: all outputs return to reset values immediately (asynchronous); no `auxStart` is issued. The buffer must hold its packet until it sees `auxStart`.
- Frame wrap: `vCount` going from `V_TOTAL-1` to 0 with `vNext == 0` means the video lead-in occurs on the last blanking line.

## Structure
- The shared HDMI package holds:
  - `STATE_t` (existing)
  - the preamble constants `VIDEO_PREAMBLE_CTL = 4'b0001` and `AUXIL_PREAMBLE_CTL = 4'b0101`
  - `PREAMBLE_LEN = 8`, `GUARD_LEN = 2`, `ISLAND_LEN = 32`
- One sub-module, `hdmi_raster_counter`: the H/V counters, sync decode and `vNext`. The sequencer FSM (`IDLE`, `PRE`, `LGUARD`, `DATA`, `TGUARD`) for islands sits on top of it.

## Test plan
- Reset, then release → `pixelY = 480` and `state = CONTROL`. After 45×800 cycles, `pixelX = 0`, `pixelY = 0`, `state = VIDEO_ISLAND`.
- Line 0 with `auxReady = 0` → `CONTROL` across the entire blanking except `VIDEO_PREAMBLE` at h = 790..797 (`ctrl1 = 2'b01`, `ctrl2 = 2'b00`) and `VIDEO_GUARD` at h = 798..799.
- `auxReady = 1` at h = 640 → `AUXIL_PREAMBLE` at h = 650..657 (`ctrl1 = 01`, `ctrl2 = 01`), guard at 658..659, `auxStart` high only at h = 660, `auxIndex` 0..31 over h = 660..691, guard at 692..693.
- hsync during an island → `ctrl0[0]` low exactly at h = 656..751 while the island proceeds unchanged.
- Last active line (v = 479) → no `VIDEO_PREAMBLE`. On line 524 → lead-in present before the wrap to v = 0.
- Assert `rst_n` low at h = 670 mid-island → outputs go to reset values in the same cycle. After release, no `auxStart` until a new `auxReady` sample.

Source files
------------

// File: rtl/hdmi_period_sequencer_pkg.sv
// Shared HDMI transmitter types: period codes, preamble CTL patterns
// and the fixed data-island phase lengths.
package hdmi_period_sequencer_pkg;

  typedef enum logic [2:0] {
    CONTROL,
    VIDEO_PREAMBLE,
    VIDEO_GUARD,
    VIDEO_ISLAND,
    AUXIL_PREAMBLE,
    AUXIL_GUARD,
    AUXIL_ISLAND
  } STATE_t;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    LGUARD,
    DATA,
    TGUARD
  } island_t;

  localparam logic [3:0] VIDEO_PREAMBLE_CTL = 4'b0001;
  localparam logic [3:0] AUXIL_PREAMBLE_CTL = 4'b0101;

  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;
  localparam int ISLAND_LEN   = 32;

  function automatic logic [3:0] ctlFor(STATE_t s);
    return (s == VIDEO_PREAMBLE) ? VIDEO_PREAMBLE_CTL :
           (s == AUXIL_PREAMBLE) ? AUXIL_PREAMBLE_CTL :
                                   4'b0000;
  endfunction

endpackage

// File: rtl/hdmi_raster_counter.sv
// Horizontal/vertical raster counters with next-character sync decode
// and the index of the line following the next character.
module hdmi_raster_counter #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [10:0] hCount,
  output logic [9:0]  vCount,
  output logic [10:0] hSucc,
  output logic [9:0]  vSucc,
  output logic [9:0]  vNext,
  output logic        hsyncSucc,
  output logic        vsyncSucc
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [9:0]  V_RST  = 10'(V_ACTIVE);

  // Everything here describes the character after the current one.
  always_comb begin
    hSucc = (hCount == H_LAST) ? '0 : hCount + 11'd1;
    vSucc = vCount;
    if (hCount == H_LAST)
      vSucc = (vCount == V_LAST) ? '0 : vCount + 10'd1;
    vNext = (vSucc == V_LAST) ? '0 : vSucc + 10'd1;
    hsyncSucc = (hSucc >= HS_BEG && hSucc < HS_END) ?
                SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsyncSucc = (vSucc >= VS_BEG && vSucc < VS_END) ?
                SYNC_ACTIVE : ~SYNC_ACTIVE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hCount <= '0;
      vCount <= V_RST;
    end else begin
      hCount <= hSucc;
      vCount <= vSucc;
    end
  end

endmodule

// File: rtl/hdmi_period_sequencer.sv
// Pixel-clock period sequencer: video lead-in, one data island per line
// and registered control codes for the three TMDS channels.
module hdmi_period_sequencer
  import hdmi_period_sequencer_pkg::*;
#(
  parameter int   H_ACTIVE     = 640,
  parameter int   H_FRONT      = 16,
  parameter int   H_SYNC       = 96,
  parameter int   H_BACK       = 48,
  parameter int   V_ACTIVE     = 480,
  parameter int   V_FRONT      = 10,
  parameter int   V_SYNC       = 2,
  parameter int   V_BACK       = 33,
  parameter logic SYNC_ACTIVE  = 1'b0,
  parameter int   ISLAND_START = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        auxReady,
  output logic        auxStart,
  output logic [4:0]  auxIndex,
  output STATE_t      state,
  output logic [1:0]  ctrl0,
  output logic [1:0]  ctrl1,
  output logic [1:0]  ctrl2,
  output logic [10:0] pixelX,
  output logic [9:0]  pixelY,
  output logic        videoActive
);

  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int ISL_SPAN = PREAMBLE_LEN + 2 * GUARD_LEN + ISLAND_LEN;

  localparam logic [10:0] H_ACT_W  = 11'(H_ACTIVE);
  localparam logic [10:0] ISL_BASE = 11'(H_ACTIVE + ISLAND_START);
  localparam logic [10:0] LEAD_PRE = 11'(H_TOTAL - 10);
  localparam logic [10:0] LEAD_GRD = 11'(H_TOTAL - 2);
  localparam logic [9:0]  V_ACT_W  = 10'(V_ACTIVE);

  if (H_TOTAL - H_ACTIVE < ISLAND_START + ISL_SPAN + 12 + 10 ||
      ISLAND_START < 4) begin : gParamCheck
    $error("hdmi_period_sequencer: blanking too short for island");
  end

  logic [10:0] hCount, hSucc;
  logic [9:0]  vCount, vSucc, vNext;
  logic        hsyncSucc, vsyncSucc;

  hdmi_raster_counter #(
    .H_ACTIVE    (H_ACTIVE),
    .H_FRONT     (H_FRONT),
    .H_SYNC      (H_SYNC),
    .H_BACK      (H_BACK),
    .V_ACTIVE    (V_ACTIVE),
    .V_FRONT     (V_FRONT),
    .V_SYNC      (V_SYNC),
    .V_BACK      (V_BACK),
    .SYNC_ACTIVE (SYNC_ACTIVE)
  ) uRaster (
    .clk       (clk),
    .rst_n     (rst_n),
    .hCount    (hCount),
    .vCount    (vCount),
    .hSucc     (hSucc),
    .vSucc     (vSucc),
    .vNext     (vNext),
    .hsyncSucc (hsyncSucc),
    .vsyncSucc (vsyncSucc)
  );

  island_t     phase, phaseD;
  logic [4:0]  cnt, cntD;
  logic        islandPending, pendingD;
  STATE_t      stateD;
  logic [3:0]  ctl;
  logic        auxStartD;
  logic [4:0]  auxIndexD;

  always_comb begin
    phaseD   = phase;
    cntD     = cnt + 5'd1;
    pendingD = islandPending;
    if (hCount == H_ACT_W)
      pendingD = auxReady;
    unique case (phase)
      IDLE: begin
        cntD = '0;
        if (islandPending && hSucc == ISL_BASE)
          phaseD = PRE;
      end
      PRE: if (cnt == 5'(PREAMBLE_LEN - 1)) begin
        phaseD = LGUARD;
        cntD   = '0;
      end
      LGUARD: if (cnt == 5'(GUARD_LEN - 1)) begin
        phaseD = DATA;
        cntD   = '0;
      end
      DATA: if (cnt == 5'(ISLAND_LEN - 1)) begin
        phaseD = TGUARD;
        cntD   = '0;
      end
      TGUARD: if (cnt == 5'(GUARD_LEN - 1)) begin
        phaseD   = IDLE;
        cntD     = '0;
        pendingD = 1'b0;
      end
      default: begin
        phaseD = IDLE;
        cntD   = '0;
      end
    endcase
  end

  // Island phases only occur in horizontal blanking, ahead of the lead-in.
  always_comb begin
    stateD    = CONTROL;
    auxStartD = 1'b0;
    auxIndexD = '0;
    unique case (1'b1)
      phaseD == PRE:
        stateD = AUXIL_PREAMBLE;
      phaseD == LGUARD || phaseD == TGUARD:
        stateD = AUXIL_GUARD;
      phaseD == DATA: begin
        stateD    = AUXIL_ISLAND;
        auxIndexD = cntD;
        auxStartD = phase != DATA;
      end
      hSucc < H_ACT_W && vSucc < V_ACT_W:
        stateD = VIDEO_ISLAND;
      vNext < V_ACT_W && hSucc >= LEAD_GRD:
        stateD = VIDEO_GUARD;
      vNext < V_ACT_W && hSucc >= LEAD_PRE && hSucc < LEAD_GRD:
        stateD = VIDEO_PREAMBLE;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase         <= IDLE;
      cnt           <= '0;
      islandPending <= 1'b0;
      state         <= CONTROL;
      ctl           <= '0;
      ctrl0         <= {~SYNC_ACTIVE, ~SYNC_ACTIVE};
      auxStart      <= 1'b0;
      auxIndex      <= '0;
      videoActive   <= 1'b0;
    end else begin
      phase         <= phaseD;
      cnt           <= cntD;
      islandPending <= pendingD;
      state         <= stateD;
      ctl           <= ctlFor(stateD);
      ctrl0         <= {vsyncSucc, hsyncSucc};
      auxStart      <= auxStartD;
      auxIndex      <= auxIndexD;
      videoActive   <= stateD == VIDEO_ISLAND;
    end
  end

  assign ctrl1  = ctl[1:0];
  assign ctrl2  = ctl[3:2];
  assign pixelX = hCount;
  assign pixelY = vCount;

endmodule

// File: tb/tb_hdmi_period_sequencer.sv
// Bench for hdmi_period_sequencer: random auxReady against a line/offset
// reference model, plus table vectors and reset/frame-wrap sequences.
module tb_hdmi_period_sequencer;
  import hdmi_period_sequencer_pkg::*;

  localparam int HA  = 640;
  localparam int HT  = 800;
  localparam int VA  = 8;
  localparam int VF  = 2;
  localparam int VS  = 2;
  localparam int VB  = 3;
  localparam int VT  = VA + VF + VS + VB;
  localparam int ISL = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        auxReady = 1'b0;
  logic        auxStart;
  logic [4:0]  auxIndex;
  STATE_t      state;
  logic [1:0]  ctrl0, ctrl1, ctrl2;
  logic [10:0] pixelX;
  logic [9:0]  pixelY;
  logic        videoActive;

  hdmi_period_sequencer #(
    .H_ACTIVE(HA), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE(1'b0), .ISLAND_START(ISL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .auxReady(auxReady),
    .auxStart(auxStart), .auxIndex(auxIndex), .state(state),
    .ctrl0(ctrl0), .ctrl1(ctrl1), .ctrl2(ctrl2),
    .pixelX(pixelX), .pixelY(pixelY), .videoActive(videoActive)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nBad = 0;
  int mh, mv;
  bit flag;

  typedef struct {
    int v; int h; bit aux; STATE_t st;
    logic [1:0] c0; logic [1:0] c1; logic [1:0] c2;
    bit s; int idx;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h want %h (h=%0d v=%0d)",
               name, act, exp, mh, mv);
    end
  endtask

  function automatic logic [63:0] dutVec();
    return 64'({state, ctrl0, ctrl1, ctrl2, auxStart, auxIndex,
                pixelX, pixelY, videoActive});
  endfunction

  function automatic logic [63:0] dutCore();
    return 64'({state, ctrl0, ctrl1, ctrl2, auxStart, auxIndex});
  endfunction

  // Expected character at (h, v) derived from line position alone.
  function automatic logic [63:0] model(int h, int v, bit fl);
    STATE_t st = CONTROL;
    logic [3:0] ctl;
    bit s = 0;
    int idx = 0;
    int off = h - (HA + ISL);
    logic hs, vs;
    if (fl && off >= 0 && off < 44) begin
      if (off < 8) st = AUXIL_PREAMBLE;
      else if (off < 10) st = AUXIL_GUARD;
      else if (off < 42) begin
        st = AUXIL_ISLAND;
        idx = off - 10;
        s = (off == 10);
      end else st = AUXIL_GUARD;
    end else if (h < HA && v < VA)
      st = VIDEO_ISLAND;
    else if ((v + 1) % VT < VA && h >= HT - 10)
      st = (h >= HT - 2) ? VIDEO_GUARD : VIDEO_PREAMBLE;
    ctl = (st == VIDEO_PREAMBLE) ? 4'b0001 :
          (st == AUXIL_PREAMBLE) ? 4'b0101 : 4'b0000;
    hs = (h >= HA + 16 && h < HA + 16 + 96) ? 1'b0 : 1'b1;
    vs = (v >= VA + VF && v < VA + VF + VS) ? 1'b0 : 1'b1;
    return 64'({st, vs, hs, ctl[1:0], ctl[3:2], s, idx[4:0],
                h[10:0], v[9:0], st == VIDEO_ISLAND});
  endfunction

  function automatic vec_t mk(int v, int h, bit aux, STATE_t st,
      logic [1:0] c0, logic [1:0] c1, logic [1:0] c2, bit s, int idx);
    vec_t e;
    e.v = v; e.h = h; e.aux = aux; e.st = st;
    e.c0 = c0; e.c1 = c1; e.c2 = c2; e.s = s; e.idx = idx;
    return e;
  endfunction

  task automatic step(bit a);
    @(posedge clk);
    #1;
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv = (mv + 1) % VT;
    end
    chk("cycle", dutVec(), model(mh, mv, flag));
    auxReady = a;
    if (mh == HA) flag = a;
  endtask

  task automatic runTo(int v, int h, bit a);
    int n = 0;
    while (!(mv == v && mh == h) && n < 20000) begin
      step(a);
      n++;
    end
    chk("reach", 64'({pixelY, pixelX}), 64'({v[9:0], h[10:0]}));
  endtask

  initial begin
    int starts;
    logic [4:0] ix;
    #2 rst_n = 1'b0;
    #1;
    mh = 0; mv = VA; flag = 0;
    chk("resetState", dutVec(), model(0, VA, 0));
    chk("resetY", 64'(pixelY), 64'(VA));
    @(negedge clk);
    rst_n = 1'b1;

    repeat ((VT - VA) * HT) step(1'($urandom_range(0, 1)));
    chk("frameStart", 64'({pixelY, pixelX, state}),
        64'({10'd0, 11'd0, VIDEO_ISLAND}));

    tbl.push_back(mk(0,   1, 0, VIDEO_ISLAND,   2'b11, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 639, 0, VIDEO_ISLAND,   2'b11, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 640, 0, CONTROL,        2'b11, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 650, 0, CONTROL,        2'b11, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 656, 0, CONTROL,        2'b10, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 789, 0, CONTROL,        2'b11, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 790, 0, VIDEO_PREAMBLE, 2'b11, 2'b01, 2'b00, 0, 0));
    tbl.push_back(mk(0, 797, 0, VIDEO_PREAMBLE, 2'b11, 2'b01, 2'b00, 0, 0));
    tbl.push_back(mk(0, 798, 0, VIDEO_GUARD,    2'b11, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 799, 0, VIDEO_GUARD,    2'b11, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(1,   0, 0, VIDEO_ISLAND,   2'b11, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(1, 640, 1, CONTROL,        2'b11, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(1, 649, 1, CONTROL,        2'b11, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(1, 650, 1, AUXIL_PREAMBLE, 2'b11, 2'b01, 2'b01, 0, 0));
    tbl.push_back(mk(1, 655, 1, AUXIL_PREAMBLE, 2'b11, 2'b01, 2'b01, 0, 0));
    tbl.push_back(mk(1, 656, 1, AUXIL_PREAMBLE, 2'b10, 2'b01, 2'b01, 0, 0));
    tbl.push_back(mk(1, 657, 1, AUXIL_PREAMBLE, 2'b10, 2'b01, 2'b01, 0, 0));
    tbl.push_back(mk(1, 658, 1, AUXIL_GUARD,    2'b10, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(1, 659, 1, AUXIL_GUARD,    2'b10, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(1, 660, 1, AUXIL_ISLAND,   2'b10, 2'b00, 2'b00, 1, 0));
    tbl.push_back(mk(1, 661, 1, AUXIL_ISLAND,   2'b10, 2'b00, 2'b00, 0, 1));
    tbl.push_back(mk(1, 691, 1, AUXIL_ISLAND,   2'b10, 2'b00, 2'b00, 0, 31));
    tbl.push_back(mk(1, 692, 1, AUXIL_GUARD,    2'b10, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(1, 693, 1, AUXIL_GUARD,    2'b10, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(1, 694, 1, CONTROL,        2'b10, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(1, 751, 1, CONTROL,        2'b10, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(1, 752, 1, CONTROL,        2'b11, 2'b00, 2'b00, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      runTo(tbl[i].v, tbl[i].h, tbl[i].aux);
      ix = tbl[i].idx[4:0];
      chk($sformatf("tbl%0d", i), dutCore(),
          64'({tbl[i].st, tbl[i].c0, tbl[i].c1, tbl[i].c2,
               tbl[i].s, ix}));
    end

    runTo(VA - 1, 790, 0);
    chk("lastActiveNoLead", 64'({state, ctrl1}), 64'({CONTROL, 2'b00}));
    runTo(VA + VF, 0, 0);
    chk("vsyncOn", 64'(ctrl0), 64'(2'b01));
    runTo(VT - 1, 790, 0);
    chk("wrapLeadPre", 64'({state, ctrl1, ctrl2}),
        64'({VIDEO_PREAMBLE, 2'b01, 2'b00}));
    runTo(VT - 1, 799, 0);
    chk("wrapLeadGuard", 64'(state), 64'(VIDEO_GUARD));
    step(0);
    chk("wrapFirst", 64'({pixelY, pixelX, state}),
        64'({10'd0, 11'd0, VIDEO_ISLAND}));

    runTo(1, 640, 1);
    runTo(1, 670, 0);
    chk("midIsland", 64'({state, auxIndex}), 64'({AUXIL_ISLAND, 5'd10}));
    rst_n = 1'b0;
    #1;
    chk("rstAsync", dutVec(), model(0, VA, 0));
    @(negedge clk);
    rst_n = 1'b1;
    mh = 0; mv = VA; flag = 0;
    auxReady = 1'b1;
    starts = 0;
    repeat (HA - 1) begin
      step(1);
      if (auxStart) starts++;
    end
    chk("noStartAfterRst", 64'(starts), 64'(0));
    runTo(VA, HA + ISL + 10, 1);
    chk("startAfterSample", 64'({auxStart, auxIndex}), 64'({1'b1, 5'd0}));

    repeat (VT * HT) step(1'($urandom_range(0, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
